// File: rtl/cla_pkg.sv
// Shared types and constants for the cache-line adapter.
// The FSM state encoding lives here so the top and any tooling agree on it.
package cla_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int N_BEATS = LINE_W / BURST_W;
  localparam int BEAT_W  = $clog2(N_BEATS);

  localparam logic [31:0] OFFSET_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } cla_state_t;

endpackage

// File: rtl/cla_perf_counter.sv
// Saturating 32-bit event counter used for the adapter's burst statistics.
// It stops at all-ones so a long run never wraps back to a small value.
module cla_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line reads/writes into 4-beat 64-bit memory bursts.
// Define CLA_PERF_CNT_EN to build the saturating read/write burst counters.
module cacheline_adapter
  import cla_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [LINE_W-1:0]   line_i,
  output logic [LINE_W-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [BURST_W-1:0]  burst_i,
  output logic [BURST_W-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i,
  output logic [31:0]         rd_cnt_o,
  output logic [31:0]         wr_cnt_o
);

  cla_state_t          state;
  logic [BEAT_W-1:0]   beat;
  logic [31:0]         addr_q;
  logic [LINE_W-1:0]   fill_q;
  logic [LINE_W-1:0]   wb_q;
  logic                last_beat;

  assign last_beat = resp_i && (beat == BEAT_W'(N_BEATS - 1));

  // Fill and writeback buffers are separate so line_o holds the last fill across writebacks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      addr_q <= '0;
      // NOTE: these buffers are plain flops rather than a RAM macro, so resetting them is legal and keeps line_o defined.
      fill_q <= '0;
      wb_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every branch sees the pre-edge beat and state.
      case (state)
        IDLE: begin
          beat <= '0;
          if (write_i) begin
            addr_q <= address_i & OFFSET_MASK;
            wb_q   <= line_i;
            state  <= WR_BURST;
          end else if (read_i) begin
            addr_q <= address_i & OFFSET_MASK;
            state  <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            fill_q[beat*BURST_W +: BURST_W] <= burst_i;
            beat <= beat + 1'b1;
            if (last_beat) state <= DONE;
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            beat <= beat + 1'b1;
            if (last_beat) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign read_o    = (state == RD_BURST);
  assign write_o   = (state == WR_BURST);
  assign resp_o    = (state == DONE);
  assign address_o = addr_q;
  assign line_o    = fill_q;
  assign burst_o   = write_o ? wb_q[beat*BURST_W +: BURST_W] : '0;

`ifdef CLA_PERF_CNT_EN
  cla_perf_counter u_rd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (read_o && last_beat),
    .cnt (rd_cnt_o)
  );

  cla_perf_counter u_wr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (write_o && last_beat),
    .cnt (wr_cnt_o)
  );
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: table of line transactions driven
// against a beat-level memory model, plus reset/arbitration/idle corner sequences.
module tb_cacheline_adapter;
  import cla_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [LINE_W-1:0]  line_i = '0;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i = '0;
  logic               read_i = 1'b0;
  logic               write_i = 1'b0;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i = '0;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i = 1'b0;
  logic [31:0]        rd_cnt_o;
  logic [31:0]        wr_cnt_o;

  always #5 clk = ~clk;

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i),
    .rd_cnt_o  (rd_cnt_o),
    .wr_cnt_o  (wr_cnt_o)
  );

  // ack: bit k is resp_i for the k-th busy cycle (1 beyond bit 7); data is the
  // line memory returns (read) or the line to write back (write).
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [255:0] data;
    logic [7:0]  ack;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rd    = 0;
  int n_wr    = 0;

  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [255:0] last_fill = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v, input logic also_read);
    address_i = v.addr;
    line_i    = v.wr ? v.data : {8{$urandom}};
    write_i   = v.wr;
    read_i    = !v.wr || also_read;
    exp_addr_q.push_back(v.addr & 32'hFFFF_FFE0);
    if (v.wr) begin
      for (int i = 0; i < 4; i++) exp_beat_q.push_back(v.data[64*i +: 64]);
    end else begin
      exp_line_q.push_back(v.data);
    end
  endtask

  // Memory model: acknowledges beats per v.ack and checks everything the DUT emits.
  task automatic serve(input vec_t v, input logic keep_read);
    int   cyc   = 0;
    int   acks  = 0;
    int   zeros = 0;
    int   k     = 0;
    logic got   = 1'b0;
    logic ack;
    logic [31:0]  ea;
    logic [255:0] el;
    ea = exp_addr_q.pop_front();
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (resp_o) begin
        got = 1'b1;
        check("done_strobes", {read_o, write_o}, 2'b00);
        if (!v.wr) begin
          el = exp_line_q.pop_front();
          check("fill_line", line_o, el);
          last_fill = el;
          n_rd++;
        end else begin
          check("line_stable_on_wb", line_o, last_fill);
          check("wb_queue_empty", exp_beat_q.size(), 0);
          n_wr++;
        end
        check("beats_taken", acks, 4);
        check("latency", cyc, 5 + zeros);
        write_i = 1'b0;
        if (!keep_read) read_i = 1'b0;
        resp_i = 1'b0;
      end else if (read_o || write_o) begin
        check("address_o", address_o, ea);
        check("burst_kind", {read_o, write_o}, v.wr ? 2'b01 : 2'b10);
        ack = (k < 8) ? v.ack[k] : 1'b1;
        k++;
        if (!ack) zeros++;
        if (write_o && ack) begin
          if (exp_beat_q.size() > 0) check("wb_beat", burst_o, exp_beat_q.pop_front());
          else check("extra_wb_beat", 1'b1, 1'b0);
        end
        if (read_o && ack && acks < 4) burst_i = v.data[64*acks +: 64];
        else burst_i = {$urandom, $urandom};
        if (ack) acks++;
        resp_i = ack;
      end else begin
        resp_i = 1'b0;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no resp_o within 200 cycles for addr %h", v.addr);
      write_i = 1'b0;
      read_i  = 1'b0;
      resp_i  = 1'b0;
    end
    @(negedge clk);
    check("resp_single", resp_o, 1'b0);
  endtask

  vec_t vecs[4];
  vec_t wb_v, rd_v;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1234,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 8'hFF};
    vecs[1] = '{1'b1, 32'h8000_003F,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 8'hFF};
    vecs[2] = '{1'b0, 32'h0000_5A5C,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'hDEAD_BEEF_CAFE_F00D, 64'h0F0F_F0F0_A5A5_5A5A}, 8'hF2};
    vecs[3] = '{1'b1, 32'h1234_5678,
                {64'h1010_2020_3030_4040, 64'h5050_6060_7070_8080,
                 64'h9090_A0A0_B0B0_C0C0, 64'hD0D0_E0E0_F0F0_0101}, 8'hEA};
    wb_v = '{1'b1, 32'h0000_0FFF,
             {64'h7777_0000_7777_0000, 64'h6666_0000_6666_0000,
              64'h5555_0000_5555_0000, 64'h4444_0000_4444_0000}, 8'hFF};
    rd_v = '{1'b0, 32'h0000_2000,
             {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
              64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101}, 8'hFF};

    // Power-on reset: every output must be zero.
    #2 rst = 1'b1;
    #1;
    check("rst_read_o",    read_o,    1'b0);
    check("rst_write_o",   write_o,   1'b0);
    check("rst_resp_o",    resp_o,    1'b0);
    check("rst_address_o", address_o, 32'h0);
    check("rst_line_o",    line_o,    256'h0);
    check("rst_burst_o",   burst_o,   64'h0);
    check("rst_rd_cnt",    rd_cnt_o,  32'h0);
    check("rst_wr_cnt",    wr_cnt_o,  32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a read: two beats land, then rst kills the burst.
    @(negedge clk);
    address_i = 32'h0000_4444;
    read_i    = 1'b1;
    @(negedge clk);
    check("mid_rd_active", read_o, 1'b1);
    resp_i  = 1'b1;
    burst_i = 64'hAAAA_0000_0000_0001;
    @(negedge clk);
    burst_i = 64'hAAAA_0000_0000_0002;
    @(negedge clk);
    resp_i = 1'b0;
    check("mid_rd_partial", line_o[127:0], {64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001});
    check("mid_rd_still_busy", read_o, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_read_o", read_o, 1'b0);
    check("mid_rst_resp_o", resp_o, 1'b0);
    check("mid_rst_line_o", line_o, 256'h0);
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {read_o, write_o, resp_o}, 3'b000);

    // Table-driven transactions, starting with the recovery read.
    for (int i = 0; i < 4; i++) begin
      drive_req(vecs[i], 1'b0);
      serve(vecs[i], 1'b0);
    end

    // read_i and write_i together: writeback goes first, fill follows.
    drive_req(wb_v, 1'b1);
    serve(wb_v, 1'b1);
    check("read_held_after_wb", read_i, 1'b1);
    drive_req(rd_v, 1'b0);
    serve(rd_v, 1'b0);

    // resp_i while idle must be ignored.
    resp_i  = 1'b1;
    burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_burst", {read_o, write_o, resp_o}, 3'b000);
    end
    resp_i = 1'b0;
    check("idle_line_kept", line_o, last_fill);

`ifdef CLA_PERF_CNT_EN
    check("rd_cnt", rd_cnt_o, 32'(n_rd));
    check("wr_cnt", wr_cnt_o, 32'(n_wr));
`else
    check("rd_cnt_off", rd_cnt_o, 32'h0);
    check("wr_cnt_off", wr_cnt_o, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
